// File: rtl/rgb_mux_scan.sv
// Switch-to-RGB selector: registered/auto-scanned channel select plus global PWM brightness.
// Define RGB_MUX_SCAN_SW_SYNC_EN to pass mode/sel_in/data_in/duty through two-flop synchronizers.
module rgb_mux_scan #(
    parameter int unsigned CH       = 3,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned SCAN_DIV = 100000000,
    parameter int unsigned DIV_W    = 27,
    parameter int unsigned PWM_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel_in,
    input  logic [CH*(2**SEL_W)-1:0]    data_in,
    input  logic [PWM_W-1:0]            duty,
    output logic [CH-1:0]               led_out,
    output logic [SEL_W-1:0]            sel_cur,
    output logic                        scan_tick
);

    localparam int unsigned        NIn     = 2 ** SEL_W;
    localparam logic [DIV_W-1:0]   DivLast = DIV_W'(SCAN_DIV - 1);
    localparam logic [PWM_W-1:0]   PwmMax  = '1;

    logic                 mode_w;
    logic [SEL_W-1:0]     sel_w;
    logic [CH*NIn-1:0]    data_w;
    logic [PWM_W-1:0]     duty_w;

`ifdef RGB_MUX_SCAN_SW_SYNC_EN
    logic                 mode_s1_q, mode_s2_q;
    logic [SEL_W-1:0]     sel_s1_q, sel_s2_q;
    logic [CH*NIn-1:0]    data_s1_q, data_s2_q;
    logic [PWM_W-1:0]     duty_s1_q, duty_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            duty_s1_q <= '0;
            duty_s2_q <= '0;
        end else begin
            mode_s1_q <= mode;
            mode_s2_q <= mode_s1_q;
            sel_s1_q  <= sel_in;
            sel_s2_q  <= sel_s1_q;
            data_s1_q <= data_in;
            data_s2_q <= data_s1_q;
            duty_s1_q <= duty;
            duty_s2_q <= duty_s1_q;
        end
    end

    assign mode_w = mode_s2_q;
    assign sel_w  = sel_s2_q;
    assign data_w = data_s2_q;
    assign duty_w = duty_s2_q;
`else
    assign mode_w = mode;
    assign sel_w  = sel_in;
    assign data_w = data_in;
    assign duty_w = duty;
`endif

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [CH-1:0]    led_q, led_d;
    logic             tick_q, tick_d;

    logic [CH-1:0]    mux_bit;
    logic [NIn-1:0]   grp;
    logic             pwm_on;

    always_comb begin
        sel_d   = sel_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        pwm_d   = pwm_q + PWM_W'(1);
        duty_d  = duty_q;
        mux_bit = '0;
        grp     = '0;

        // Manual mode also suppresses a tick that would land on the 1->0 edge.
        if (mode_w) begin
            if (div_q == DivLast) begin
                div_d  = '0;
                tick_d = 1'b1;
                sel_d  = sel_q + SEL_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            sel_d = sel_w;
            div_d = '0;
        end

        // Brightness only changes at a period boundary so no partial period is emitted.
        if (pwm_q == PwmMax) begin
            duty_d = duty_w;
        end
        pwm_on = (duty_q == PwmMax) || (pwm_q < duty_q);

        for (int unsigned c = 0; c < CH; c++) begin
            grp        = data_w[c*NIn +: NIn];
            mux_bit[c] = grp[sel_q];
        end
        led_d = mux_bit & {CH{pwm_on}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            div_q  <= '0;
            pwm_q  <= '0;
            duty_q <= '0;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            div_q  <= div_d;
            pwm_q  <= pwm_d;
            duty_q <= duty_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led_out   = led_q;
    assign sel_cur   = sel_q;
    assign scan_tick = tick_q;

endmodule

// File: doc/rgb_mux_scan.md
Name: rgb_mux_scan

Overview:
- Parametrised successor to the lab's switch-driven RGB LED selector: CH output channels, each choosing one of 2**SEL_W switch inputs through a common select.
- Adds a registered select with an auto-scan mode that steps the select on a programmable divider.
- Adds a global PWM brightness stage on every channel output.
- Sits between the board switches and the RGB LED pins at the top level.

Parameters:
- CH, 3, number of output channels (R,G,B by default)
- SEL_W, 2, select width; inputs per channel N_IN = 2**SEL_W
- SCAN_DIV, 100000000, clocks per auto-scan step (1 s at 100 MHz); legal range 2..2**DIV_W-1
- DIV_W, 27, width of the scan divider counter
- PWM_W, 8, width of the PWM counter and duty input

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = manual select from sel_in, 1 = auto-scan
- sel_in  input  SEL_W  manual select value
- data_in  input  CH*N_IN  channel c input k at bit c*N_IN+k
- duty  input  PWM_W  brightness; 0 = off, all-ones = fully on
- led_out  output  CH  registered, PWM-gated channel outputs
- sel_cur  output  SEL_W  current registered select (sel_q)
- scan_tick  output  1  one-cycle pulse on each auto-scan step

Behaviour:
- Reset (rst=1 at clk edge):
  - sel_q=0, div_cnt=0, pwm_cnt=0, duty_q=0.
  - led_out=0, scan_tick=0.
  - Reset overrides every other event in the same cycle.
  - Reset mid-scan or mid-PWM-period restarts both counters from 0.
- Manual mode (mode=0):
  - sel_q <= sel_in every cycle.
  - div_cnt held at 0; scan_tick=0.
- Auto mode (mode=1):
  - div_cnt increments each cycle.
  - When div_cnt==SCAN_DIV-1: div_cnt<=0, scan_tick<=1 for exactly one cycle, sel_q<=sel_q+1 mod N_IN (wrap N_IN-1 -> 0).
  - sel_in is ignored.
- Mode change:
  - 0->1: scan continues from the current sel_q; div_cnt starts from 0, so the first step occurs SCAN_DIV cycles after the first cycle with mode=1.
  - 1->0: sel_q takes sel_in at the next edge; div_cnt is cleared.
  - A tick coinciding with the 1->0 change is suppressed.
- Mux:
  - mux_bit[c] = data_in[c*N_IN + sel_q], combinational from sel_q.
- PWM:
  - pwm_cnt free-runs 0..2**PWM_W-1 and wraps.
  - duty_q <= duty only in the cycle pwm_cnt == all-ones (glitch-free update at period boundary).
  - pwm_on = (duty_q == all-ones) | (pwm_cnt < duty_q).
  - Resulting on-time: duty 0 = 0 %; duty 128 = 128/256 cycles; all-ones = 100 %.
- Output:
  - led_out[c] <= mux_bit[c] & pwm_on, registered.
- Latency (duty at all-ones):
  - data_in -> led_out: 1 clk.
  - sel_in -> led_out: 2 clk.
  - scan_tick is asserted in the same cycle sel_q shows the new value.
- Widths:
  - sel_q increments in SEL_W bits with natural wrap.
  - div_cnt compare is a full DIV_W-bit equality.

Optional Feature:
- Macro: RGB_MUX_SCAN_SW_SYNC_EN
- Defined: mode, sel_in, data_in and duty each pass through a two-flop synchronizer clocked by clk, reset to 0 by rst. All input-to-output latencies grow by 2 clk.
- Undefined: inputs are used directly and latencies are as stated above.

Test Plan:
- Reset: drive rst=1 for 3 clk with data_in all-ones, duty=255 -> led_out=0, sel_cur=0, scan_tick=0 throughout; after release, led_out=3'b111 within 2 clk once duty_q loads at first pwm wrap.
- Manual select: mode=0, duty=255, data_in=12'b0100_0010_0001, sel_in=0..3 stepped -> led_out = 001, 010, 100, 000 respectively, each 2 clk after sel_in changes.
- Auto scan (SCAN_DIV=4): mode=1 from sel_q=2 -> scan_tick every 4 clk; sel_cur sequence 2,3,0,1,2; wrap 3->0 verified; no tick while mode=0.
- Mode switch: auto with tick due in the same cycle mode drops to 0, sel_in=1 -> no scan_tick; sel_cur=1 next clk; div_cnt restarts on return to auto.
- PWM duty: PWM_W=4, data bit=1, duty=0 -> led_out never 1; duty=8 -> high 8 of 16 cycles per period; duty=15 -> constantly high. Change duty mid-period -> takes effect only after the pwm_cnt==15 cycle.
- Reset mid-operation: assert rst during auto scan at sel_cur=3, pwm_cnt=9 -> next clk sel_cur=0, led_out=0; scan restarts a full SCAN_DIV after release.
